// File: rtl/bin_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_bcd_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam logic [3:0] ADD3_THRESH = 4'd5;
   localparam logic [3:0] ADD3        = 4'd3;

   // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
   function automatic bit digits_ok(input int width, input int digits);
      longint unsigned p10 = 1;
      for (int i = 0; i < digits; i++) p10 = p10 * 10;
      return p10 > ((longint'(1) << width) - 1);
   endfunction

endpackage

// File: rtl/bin_bcd_seq_if.sv
// Start/result handshake between a binary producer and the BCD converter.
interface bin_bcd_seq_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [WIDTH-1:0]      v;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic [DIGITS-1:0]     blank;

   modport master (output start, v, input busy, done, bcd, blank);
   modport slave  (input start, v, output busy, done, bcd, blank);
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more.
module bcd_add3
   import bin_bcd_seq_pkg::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);
   assign dout = (din >= ADD3_THRESH) ? din + ADD3 : din;
endmodule

// File: rtl/bin_bcd_seq.sv
// Sequential shift-and-add-3 converter: WIDTH shift cycles, then one FINISH
// cycle that publishes BCD digits and the leading-zero blank mask.
module bin_bcd_seq
   import bin_bcd_seq_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
)(
   input  logic          Clock,
   input  logic          Reset,
   bin_bcd_seq_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

   if (WIDTH < 4) begin : g_bad_width
      $error("bin_bcd_seq: WIDTH must be at least 4");
   end
   if (!digits_ok(WIDTH, DIGITS)) begin : g_bad_digits
      $error("bin_bcd_seq: DIGITS too small for WIDTH");
   end

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      shift_q, shift_d;
   logic [4*DIGITS-1:0]   scr_q, scr_d, scr_adj;
   logic [4*DIGITS-1:0]   bcd_q, bcd_d;
   logic [DIGITS-1:0]     blank_q, blank_d, blank_new;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  done_q, done_d;
   logic                  zero_run;

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .din  (scr_q[4*g +: 4]),
         .dout (scr_adj[4*g +: 4])
      );
   end

   // Walk down from the top digit; a digit blanks only while all above it are zero.
   always_comb begin
      blank_new = '0;
      zero_run  = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run     = zero_run & (scr_q[4*i +: 4] == 4'd0);
         blank_new[i] = zero_run;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      scr_d   = scr_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      blank_d = blank_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               shift_d = bus.v;
               scr_d   = '0;
               cnt_d   = CW'(WIDTH);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {scr_d, shift_d} = {scr_adj, shift_q} << 1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = FINISH;
         end
         FINISH: begin
            bcd_d   = scr_q;
            blank_d = blank_new;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         blank_q <= BLANK_RST;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         scr_q   <= scr_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         blank_q <= blank_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy  = (state_q != IDLE);
   assign bus.done  = done_q;
   assign bus.bcd   = bcd_q;
   assign bus.blank = blank_q;

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Randomised self-check of bin_bcd_seq at three parameter sets against a
// decimal-arithmetic reference model.
module tb_bin_bcd_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   bin_bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) b8  ();
   bin_bcd_seq_if #(.WIDTH(4),  .DIGITS(2)) b4  ();
   bin_bcd_seq_if #(.WIDTH(10), .DIGITS(4)) b10 ();

   bin_bcd_seq #(.WIDTH(8),  .DIGITS(3)) u8  (.Clock(clk), .Reset(rst), .bus(b8));
   bin_bcd_seq #(.WIDTH(4),  .DIGITS(2)) u4  (.Clock(clk), .Reset(rst), .bus(b4));
   bin_bcd_seq #(.WIDTH(10), .DIGITS(4)) u10 (.Clock(clk), .Reset(rst), .bus(b10));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_bcd(input longint unsigned v, input int d);
      logic [63:0] r = '0;
      for (int i = 0; i < d; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [63:0] ref_blank(input longint unsigned v, input int d);
      logic [63:0]     r   = '0;
      longint unsigned p10 = 10;
      for (int i = 1; i < d; i++) begin
         r[i] = (v < p10);
         p10  = p10 * 10;
      end
      return r;
   endfunction

   // One conversion on the 8-bit unit; optional Start pokes in SHIFT and FINISH.
   task automatic run8(input logic [7:0] val, input bit poke);
      int n, busy_n;
      @(negedge clk); b8.start = 1'b1; b8.v = val;
      @(negedge clk); b8.start = 1'b0; b8.v = 8'($urandom);
      n = 0; busy_n = 0;
      while (!b8.done && n < 40) begin
         if (b8.busy) busy_n++;
         if (poke) b8.start = (n == 3 || n == 8);
         @(negedge clk); n++;
      end
      b8.start = 1'b0;
      check("w8_done_seen", b8.done, 1);
      check("w8_latency",   n, 9);
      check("w8_busy_cyc",  busy_n, 9);
      check("w8_bcd",       b8.bcd, ref_bcd(val, 3));
      check("w8_blank",     b8.blank, ref_blank(val, 3));
      check("w8_busy_done", b8.busy, 0);
      @(negedge clk);
      check("w8_done_pulse", b8.done, 0);
      check("w8_idle_after", b8.busy, 0);
      check("w8_bcd_hold",   b8.bcd, ref_bcd(val, 3));
   endtask

   initial begin
      int n, m, dcnt;
      logic [9:0] v10;
      b8.start = 0;  b8.v = '0;
      b4.start = 0;  b4.v = '0;
      b10.start = 0; b10.v = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy",  b8.busy, 0);
      check("rst_done",  b8.done, 0);
      check("rst_bcd",   b8.bcd, 0);
      check("rst_blank", b8.blank, 3'b110);

      run8(8'd0, 0);
      run8(8'd255, 0);
      run8(8'd15, 0);
      run8(8'd9, 1);

      // Start held high: two conversions back to back, V moved after capture.
      @(negedge clk); b8.start = 1'b1; b8.v = 8'd100;
      @(negedge clk); b8.v = 8'd42;
      n = 0;
      while (!b8.done && n < 40) begin @(negedge clk); n++; end
      check("b2b_lat1", n, 9);
      check("b2b_bcd1", b8.bcd, ref_bcd(100, 3));
      m = 0;
      do begin
         @(negedge clk); m++;
         if (m == 1) b8.v = 8'($urandom);
      end while (!b8.done && m < 40);
      b8.start = 1'b0;
      check("b2b_period", m, 10);
      check("b2b_bcd2",   b8.bcd, ref_bcd(42, 3));
      check("b2b_blank2", b8.blank, ref_blank(42, 3));
      @(negedge clk);
      check("b2b_no_third", b8.busy, 0);

      // Reset in the 4th SHIFT cycle of a conversion.
      @(negedge clk); b8.start = 1'b1; b8.v = 8'd200;
      @(negedge clk); b8.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_busy",  b8.busy, 0);
      check("mrst_bcd",   b8.bcd, 0);
      check("mrst_blank", b8.blank, 3'b110);
      check("mrst_done",  b8.done, 0);
      dcnt = 0;
      repeat (12) begin @(negedge clk); if (b8.done) dcnt++; end
      check("mrst_no_done", dcnt, 0);

      // Reset and Start together: reset wins.
      rst = 1'b1; b8.start = 1'b1; b8.v = 8'd7;
      @(negedge clk);
      rst = 1'b0; b8.start = 1'b0;
      check("rst_start_busy", b8.busy, 0);
      run8(8'd200, 0);

      for (int i = 0; i < 16; i++) run8(8'($urandom), bit'($urandom_range(0, 1)));

      // 4-bit / 2-digit unit, exhaustive.
      for (int v = 0; v < 16; v++) begin
         @(negedge clk); b4.start = 1'b1; b4.v = 4'(v);
         @(negedge clk); b4.start = 1'b0;
         n = 0;
         while (!b4.done && n < 20) begin @(negedge clk); n++; end
         check("w4_done",  b4.done, 1);
         check("w4_bcd",   b4.bcd, ref_bcd(longint'(v), 2));
         check("w4_blank", b4.blank, ref_blank(longint'(v), 2));
      end

      // 10-bit / 4-digit unit: corners then random.
      for (int i = 0; i < 10; i++) begin
         case (i)
            0: v10 = 10'd1023;
            1: v10 = 10'd0;
            2: v10 = 10'd999;
            3: v10 = 10'd1000;
            default: v10 = 10'($urandom);
         endcase
         @(negedge clk); b10.start = 1'b1; b10.v = v10;
         @(negedge clk); b10.start = 1'b0;
         n = 0;
         while (!b10.done && n < 30) begin @(negedge clk); n++; end
         check("w10_done",    b10.done, 1);
         check("w10_latency", n, 11);
         check("w10_bcd",     b10.bcd, ref_bcd(longint'(v10), 4));
         check("w10_blank",   b10.blank, ref_blank(longint'(v10), 4));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
